axi_mem_slave: RTL and testbench

- AXI4 responder (slave) with an internal 64-bit-wide word memory; the far end of the CPU's AXI master port.
- Used as simulation and FPGA backing RAM behind the CPU wrapper.
- Independent read and write engines, each with one outstanding burst.
- Supports FIXED, INCR and WRAP bursts of up to 256 beats, narrow sizes and byte strobes.

---
 rtl/axi_mem_slave.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_axi_mem_slave.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_slave.sv
// AXI4 responder backed by a 64-bit word memory; independent read and write engines, one burst each.
// Optional AXI_MEM_DECERR_EN: beats outside [BASE_ADDR, BASE_ADDR+8*MEM_WORDS) get DECERR instead of aliasing.
module axi_mem_slave #(
    parameter int unsigned MEM_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  axi_awid,
    input  logic [31:0] axi_awaddr,
    input  logic [7:0]  axi_awlen,
    input  logic [2:0]  axi_awsize,
    input  logic [1:0]  axi_awburst,
    input  logic        axi_awvalid,
    output logic        axi_awready,
    input  logic [63:0] axi_wdata,
    input  logic [7:0]  axi_wstrb,
    input  logic        axi_wlast,
    input  logic        axi_wvalid,
    output logic        axi_wready,
    output logic [3:0]  axi_bid,
    output logic [1:0]  axi_bresp,
    output logic        axi_bvalid,
    input  logic        axi_bready,
    input  logic [3:0]  axi_arid,
    input  logic [31:0] axi_araddr,
    input  logic [7:0]  axi_arlen,
    input  logic [2:0]  axi_arsize,
    input  logic [1:0]  axi_arburst,
    input  logic        axi_arvalid,
    output logic        axi_arready,
    output logic [3:0]  axi_rid,
    output logic [63:0] axi_rdata,
    output logic [1:0]  axi_rresp,
    output logic        axi_rlast,
    output logic        axi_rvalid,
    input  logic        axi_rready
);

    localparam int unsigned IDX_W = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    logic [63:0] mem [MEM_WORDS];

    function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [7:0] len,
                                              input logic [2:0] size, input logic [1:0] burst);
        logic [2:0]  es;
        logic [31:0] nxt;
        logic [31:0] mask;
        es   = (size > 3'd3) ? 3'd3 : size;
        nxt  = a + (32'd1 << es);
        mask = (({24'd0, len} + 32'd1) << es) - 32'd1;
        case (burst)
            2'b00: next_addr = a;
            2'b10: begin
                if (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)
                    next_addr = (a & ~mask) | (nxt & mask);
                else
                    next_addr = nxt;
            end
            default: next_addr = nxt;
        endcase
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
        word_idx = IDX_W'((a - BASE_ADDR) >> 3);
    endfunction

    w_state_t    w_state, w_state_n;
    logic [3:0]  aw_id, aw_id_n;
    logic [31:0] w_addr, w_addr_n;
    logic [7:0]  w_len, w_len_n, w_cnt, w_cnt_n;
    logic [2:0]  w_size, w_size_n;
    logic [1:0]  w_burst, w_burst_n;
    logic        w_slv, w_slv_n, w_dec, w_dec_n;
    logic        awready_n, wready_n, bvalid_n;
    logic [3:0]  bid_n;
    logic [1:0]  bresp_n;
    logic        w_fire, w_ok, slv_all, dec_all;

    r_state_t    r_state, r_state_n;
    logic [3:0]  ar_id, ar_id_n;
    logic [31:0] r_addr, r_addr_n, r_next, r_load_addr;
    logic [7:0]  r_len, r_len_n, r_cnt, r_cnt_n;
    logic [2:0]  r_size, r_size_n;
    logic [1:0]  r_burst, r_burst_n;
    logic        arready_n, rvalid_n, rlast_n, r_ok;
    logic [3:0]  rid_n;
    logic [63:0] rdata_n;
    logic [1:0]  rresp_n;

`ifdef AXI_MEM_DECERR_EN
    function automatic logic in_range(input logic [31:0] a);
        in_range = ((a - BASE_ADDR) >> (IDX_W + 3)) == 32'd0;
    endfunction
    assign w_ok = in_range(w_addr);
    assign r_ok = in_range(r_load_addr);
`else
    assign w_ok = 1'b1;
    assign r_ok = 1'b1;
`endif

    assign w_fire  = (w_state == W_DATA) && axi_wvalid && axi_wready;
    assign slv_all = w_slv | (axi_wlast != (w_cnt == w_len));
    assign dec_all = w_dec | ~w_ok;

    always_comb begin
        w_state_n = w_state;
        aw_id_n   = aw_id;
        w_addr_n  = w_addr;
        w_len_n   = w_len;
        w_size_n  = w_size;
        w_burst_n = w_burst;
        w_cnt_n   = w_cnt;
        w_slv_n   = w_slv;
        w_dec_n   = w_dec;
        awready_n = axi_awready;
        wready_n  = axi_wready;
        bvalid_n  = axi_bvalid;
        bid_n     = axi_bid;
        bresp_n   = axi_bresp;
        case (w_state)
            W_IDLE: begin
                awready_n = 1'b1;
                if (axi_awvalid && axi_awready) begin
                    aw_id_n   = axi_awid;
                    w_addr_n  = axi_awaddr;
                    w_len_n   = axi_awlen;
                    w_size_n  = axi_awsize;
                    w_burst_n = axi_awburst;
                    w_cnt_n   = '0;
                    w_slv_n   = 1'b0;
                    w_dec_n   = 1'b0;
                    awready_n = 1'b0;
                    wready_n  = 1'b1;
                    w_state_n = W_DATA;
                end
            end
            W_DATA: begin
                if (w_fire) begin
                    w_slv_n  = slv_all;
                    w_dec_n  = dec_all;
                    w_addr_n = next_addr(w_addr, w_len, w_size, w_burst);
                    w_cnt_n  = w_cnt + 8'd1;
                    if (w_cnt == w_len) begin
                        wready_n  = 1'b0;
                        bvalid_n  = 1'b1;
                        bid_n     = aw_id;
                        bresp_n   = dec_all ? 2'b11 : (slv_all ? 2'b10 : 2'b00);
                        w_state_n = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (axi_bvalid && axi_bready) begin
                    bvalid_n  = 1'b0;
                    awready_n = 1'b1;
                    w_state_n = W_IDLE;
                end
            end
            default: w_state_n = W_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            w_state     <= W_IDLE;
            aw_id       <= '0;
            w_addr      <= '0;
            w_len       <= '0;
            w_size      <= '0;
            w_burst     <= '0;
            w_cnt       <= '0;
            w_slv       <= 1'b0;
            w_dec       <= 1'b0;
            axi_awready <= 1'b0;
            axi_wready  <= 1'b0;
            axi_bvalid  <= 1'b0;
            axi_bid     <= '0;
            axi_bresp   <= '0;
        end else begin
            w_state     <= w_state_n;
            aw_id       <= aw_id_n;
            w_addr      <= w_addr_n;
            w_len       <= w_len_n;
            w_size      <= w_size_n;
            w_burst     <= w_burst_n;
            w_cnt       <= w_cnt_n;
            w_slv       <= w_slv_n;
            w_dec       <= w_dec_n;
            axi_awready <= awready_n;
            axi_wready  <= wready_n;
            axi_bvalid  <= bvalid_n;
            axi_bid     <= bid_n;
            axi_bresp   <= bresp_n;
        end
    end

    always_ff @(posedge clock) begin
        if (w_fire && w_ok) begin
            for (int unsigned b = 0; b < 8; b++) begin
                if (axi_wstrb[b]) mem[word_idx(w_addr)][8*b +: 8] <= axi_wdata[8*b +: 8];
            end
        end
    end

    // rdata samples the pre-edge memory, so a same-edge write is only seen by later beats.
    assign r_next      = next_addr(r_addr, r_len, r_size, r_burst);
    assign r_load_addr = axi_rvalid ? r_next : r_addr;

    always_comb begin
        r_state_n = r_state;
        ar_id_n   = ar_id;
        r_addr_n  = r_addr;
        r_len_n   = r_len;
        r_size_n  = r_size;
        r_burst_n = r_burst;
        r_cnt_n   = r_cnt;
        arready_n = axi_arready;
        rvalid_n  = axi_rvalid;
        rid_n     = axi_rid;
        rdata_n   = axi_rdata;
        rresp_n   = axi_rresp;
        rlast_n   = axi_rlast;
        case (r_state)
            R_IDLE: begin
                arready_n = 1'b1;
                if (axi_arvalid && axi_arready) begin
                    ar_id_n   = axi_arid;
                    r_addr_n  = axi_araddr;
                    r_len_n   = axi_arlen;
                    r_size_n  = axi_arsize;
                    r_burst_n = axi_arburst;
                    r_cnt_n   = '0;
                    arready_n = 1'b0;
                    r_state_n = R_DATA;
                end
            end
            R_DATA: begin
                if (!axi_rvalid) begin
                    rvalid_n = 1'b1;
                    rid_n    = ar_id;
                    rdata_n  = r_ok ? mem[word_idx(r_load_addr)] : '0;
                    rresp_n  = r_ok ? 2'b00 : 2'b11;
                    rlast_n  = (r_len == 8'd0);
                end else if (axi_rready) begin
                    if (r_cnt == r_len) begin
                        rvalid_n  = 1'b0;
                        rlast_n   = 1'b0;
                        arready_n = 1'b1;
                        r_state_n = R_IDLE;
                    end else begin
                        r_addr_n = r_next;
                        r_cnt_n  = r_cnt + 8'd1;
                        rdata_n  = r_ok ? mem[word_idx(r_load_addr)] : '0;
                        rresp_n  = r_ok ? 2'b00 : 2'b11;
                        rlast_n  = (8'(r_cnt + 8'd1) == r_len);
                    end
                end
            end
            default: r_state_n = R_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= R_IDLE;
            ar_id       <= '0;
            r_addr      <= '0;
            r_len       <= '0;
            r_size      <= '0;
            r_burst     <= '0;
            r_cnt       <= '0;
            axi_arready <= 1'b0;
            axi_rvalid  <= 1'b0;
            axi_rid     <= '0;
            axi_rdata   <= '0;
            axi_rresp   <= '0;
            axi_rlast   <= 1'b0;
        end else begin
            r_state     <= r_state_n;
            ar_id       <= ar_id_n;
            r_addr      <= r_addr_n;
            r_len       <= r_len_n;
            r_size      <= r_size_n;
            r_burst     <= r_burst_n;
            r_cnt       <= r_cnt_n;
            axi_arready <= arready_n;
            axi_rvalid  <= rvalid_n;
            axi_rid     <= rid_n;
            axi_rdata   <= rdata_n;
            axi_rresp   <= rresp_n;
            axi_rlast   <= rlast_n;
        end
    end

endmodule

// File: tb/tb_axi_mem_slave.sv
// Self-checking bench for axi_mem_slave: directed plus randomized bursts against a byte-level memory model.
// Build with AXI_MEM_DECERR_EN defined to check the out-of-range responses instead of aliasing.
module tb_axi_mem_slave;

    localparam int unsigned MW    = 512;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int unsigned LIMIT = 600;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  axi_awid;
    logic [31:0] axi_awaddr;
    logic [7:0]  axi_awlen;
    logic [2:0]  axi_awsize;
    logic [1:0]  axi_awburst;
    logic        axi_awvalid;
    logic        axi_awready;
    logic [63:0] axi_wdata;
    logic [7:0]  axi_wstrb;
    logic        axi_wlast;
    logic        axi_wvalid;
    logic        axi_wready;
    logic [3:0]  axi_bid;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid;
    logic        axi_bready;
    logic [3:0]  axi_arid;
    logic [31:0] axi_araddr;
    logic [7:0]  axi_arlen;
    logic [2:0]  axi_arsize;
    logic [1:0]  axi_arburst;
    logic        axi_arvalid;
    logic        axi_arready;
    logic [3:0]  axi_rid;
    logic [63:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rlast;
    logic        axi_rvalid;
    logic        axi_rready;

    axi_mem_slave #(.MEM_WORDS(MW), .BASE_ADDR(BASE)) dut (
        .clock(clock), .reset(reset),
        .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
        .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
        .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
        .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
    );

    always #5 clock = ~clock;

    logic [63:0] mm [MW];
    logic [63:0] wq_data [$];
    logic [7:0]  wq_strb [$];
    int unsigned compared = 0;
    int unsigned mismatched = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Address of beat n computed directly from the burst definition.
    function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [7:0] len,
                                              input logic [2:0] size, input logic [1:0] burst,
                                              input int unsigned n);
        int unsigned step;
        int unsigned span;
        logic [31:0] lo;
        step = 1 << ((size > 3'd3) ? 3 : int'(size));
        if (burst == 2'b00) return a;
        if (burst == 2'b10 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
            span = (int'(len) + 1) * step;
            lo   = (a / span) * span;
            return lo + ((a - lo + n * step) % span);
        end
        return a + n * step;
    endfunction

    function automatic int unsigned midx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (off / 8) % MW;
    endfunction

    function automatic bit dec_model(input logic [31:0] a);
`ifdef AXI_MEM_DECERR_EN
        longint unsigned la;
        la = 64'(a);
        return !(la >= 64'(BASE) && la < 64'(BASE) + 64'(8 * MW));
`else
        return (a === 32'hx);
`endif
    endfunction

    task automatic fill(input int unsigned n, input bit rnd_strb);
        for (int unsigned i = 0; i < n; i++) begin
            wq_data.push_back({$urandom, $urandom});
            wq_strb.push_back(rnd_strb ? 8'($urandom) : 8'hFF);
        end
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_awready"}, 64'(axi_awready), 64'd0);
        check({tag, "_wready"},  64'(axi_wready),  64'd0);
        check({tag, "_bvalid"},  64'(axi_bvalid),  64'd0);
        check({tag, "_bid"},     64'(axi_bid),     64'd0);
        check({tag, "_bresp"},   64'(axi_bresp),   64'd0);
        check({tag, "_arready"}, 64'(axi_arready), 64'd0);
        check({tag, "_rvalid"},  64'(axi_rvalid),  64'd0);
        check({tag, "_rid"},     64'(axi_rid),     64'd0);
        check({tag, "_rdata"},   axi_rdata,        64'd0);
        check({tag, "_rresp"},   64'(axi_rresp),   64'd0);
        check({tag, "_rlast"},   64'(axi_rlast),   64'd0);
    endtask

    task automatic wr(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                      input logic [2:0] size, input logic [1:0] burst, input int bad_beat,
                      input int unsigned bstall);
        int unsigned n;
        int unsigned k;
        bit slv;
        bit dec;
        logic [31:0] a;
        slv = 0;
        dec = 0;
        @(negedge clock);
        axi_awid = id; axi_awaddr = addr; axi_awlen = len; axi_awsize = size; axi_awburst = burst;
        axi_awvalid = 1'b1;
        n = 0;
        while (!axi_awready && n < LIMIT) begin @(negedge clock); n++; end
        check("aw_wait", 64'(n < LIMIT), 64'd1);
        @(negedge clock);
        axi_awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            axi_wdata  = wq_data[b];
            axi_wstrb  = wq_strb[b];
            axi_wlast  = (b == int'(len)) ^ (b == bad_beat);
            axi_wvalid = 1'b1;
            n = 0;
            while (!axi_wready && n < LIMIT) begin @(negedge clock); n++; end
            check("w_wait", 64'(n < LIMIT), 64'd1);
            a = beat_addr(addr, len, size, burst, b);
            if (axi_wlast != (b == int'(len))) slv = 1;
            if (dec_model(a)) dec = 1;
            else begin
                k = midx(a);
                for (int j = 0; j < 8; j++) if (axi_wstrb[j]) mm[k][8*j +: 8] = axi_wdata[8*j +: 8];
            end
            @(negedge clock);
        end
        axi_wvalid = 1'b0;
        axi_wlast  = 1'b0;
        wq_data.delete();
        wq_strb.delete();
        n = 0;
        while (!axi_bvalid && n < LIMIT) begin @(negedge clock); n++; end
        check("b_wait", 64'(n < LIMIT), 64'd1);
        for (int unsigned i = 0; i < bstall; i++) begin
            check("b_hold_valid", 64'(axi_bvalid), 64'd1);
            check("b_hold_id", 64'(axi_bid), 64'(id));
            @(negedge clock);
        end
        axi_bready = 1'b1;
        check("bvalid", 64'(axi_bvalid), 64'd1);
        check("bid", 64'(axi_bid), 64'(id));
        check("bresp", 64'(axi_bresp), dec ? 64'd3 : (slv ? 64'd2 : 64'd0));
        @(negedge clock);
        axi_bready = 1'b0;
        check("b_drop", 64'(axi_bvalid), 64'd0);
        check("aw_reready", 64'(axi_awready), 64'd1);
    endtask

    task automatic rd(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                      input logic [2:0] size, input logic [1:0] burst, input int unsigned mode);
        int unsigned n;
        int unsigned beat;
        int unsigned cyc;
        logic [31:0] a;
        bit d;
        @(negedge clock);
        axi_arid = id; axi_araddr = addr; axi_arlen = len; axi_arsize = size; axi_arburst = burst;
        axi_arvalid = 1'b1;
        n = 0;
        while (!axi_arready && n < LIMIT) begin @(negedge clock); n++; end
        check("ar_wait", 64'(n < LIMIT), 64'd1);
        @(negedge clock);
        axi_arvalid = 1'b0;
        check("r_lat0", 64'(axi_rvalid), 64'd0);
        @(negedge clock);
        check("r_lat1", 64'(axi_rvalid), 64'd1);
        beat = 0;
        cyc  = 0;
        while (beat <= int'(len) && cyc < LIMIT) begin
            case (mode)
                0:       axi_rready = 1'b1;
                1:       axi_rready = (cyc % 3 == 0);
                default: axi_rready = 1'($urandom_range(0, 1));
            endcase
            if (axi_rvalid) begin
                a = beat_addr(addr, len, size, burst, beat);
                d = dec_model(a);
                check("rdata", axi_rdata, d ? 64'd0 : mm[midx(a)]);
                check("rresp", 64'(axi_rresp), d ? 64'd3 : 64'd0);
                check("rlast", 64'(axi_rlast), 64'(beat == int'(len)));
                check("rid", 64'(axi_rid), 64'(id));
                if (axi_rready) beat++;
            end
            @(negedge clock);
            cyc++;
        end
        axi_rready = 1'b0;
        check("r_beats", 64'(beat), 64'(int'(len) + 1));
        check("r_end", 64'(axi_rvalid), 64'd0);
        check("ar_reready", 64'(axi_arready), 64'd1);
        @(negedge clock);
        check("r_no_extra", 64'(axi_rvalid), 64'd0);
    endtask

    initial begin
        int unsigned sz;
        int unsigned st;
        int unsigned ln;
        logic [31:0] ad;
        reset = 1'b0;
        axi_awid = '0; axi_awaddr = '0; axi_awlen = '0; axi_awsize = '0; axi_awburst = '0;
        axi_awvalid = 1'b0; axi_wdata = '0; axi_wstrb = '0; axi_wlast = 1'b0; axi_wvalid = 1'b0;
        axi_bready = 1'b0; axi_arid = '0; axi_araddr = '0; axi_arlen = '0; axi_arsize = '0;
        axi_arburst = '0; axi_arvalid = 1'b0; axi_rready = 1'b0;

        #1 chk_zero("rst");
        repeat (3) @(negedge clock);
        reset = 1'b1;
        check("awready_at_release", 64'(axi_awready), 64'd0);
        @(negedge clock);
        check("awready_after_release", 64'(axi_awready), 64'd1);
        check("arready_after_release", 64'(axi_arready), 64'd1);

        for (int unsigned p = 0; p < MW / 256; p++) begin
            fill(256, 0);
            wr(4'd0, BASE + 32'(p * 2048), 8'd255, 3'd3, 2'b01, -1, 0);
        end

        wq_data.push_back(64'h1122334455667788); wq_strb.push_back(8'hFF);
        wr(4'd3, 32'h8000_0010, 8'd0, 3'd3, 2'b01, -1, 0);
        rd(4'd5, 32'h8000_0010, 8'd0, 3'd3, 2'b01, 0);

        wq_data.push_back('1); wq_strb.push_back(8'hFF);
        wr(4'd1, BASE, 8'd0, 3'd3, 2'b01, -1, 0);
        wq_data.push_back(64'h0000_0000_00AB_0000); wq_strb.push_back(8'h04);
        wr(4'd2, BASE + 32'd2, 8'd0, 3'd0, 2'b01, -1, 0);
        rd(4'd2, BASE, 8'd0, 3'd3, 2'b01, 0);

        fill(8, 0);
        wr(4'd7, 32'h8000_0000, 8'd7, 3'd3, 2'b01, -1, 0);
        rd(4'd8, 32'h8000_0020, 8'd3, 3'd3, 2'b10, 0);
        rd(4'd9, 32'h8000_0030, 8'd3, 3'd3, 2'b10, 0);

        rd(4'hA, 32'h8000_0040, 8'd3, 3'd3, 2'b01, 1);
        fill(2, 1);
        wr(4'hB, 32'h8000_0048, 8'd1, 3'd3, 2'b01, -1, 5);

        fill(2, 0);
        wr(4'hC, 32'h8000_0060, 8'd1, 3'd3, 2'b01, 0, 0);
        rd(4'hC, 32'h8000_0060, 8'd1, 3'd3, 2'b00, 0);

        // Abort a write burst with reset after two of its four beats.
        @(negedge clock);
        axi_awid = 4'd6; axi_awaddr = BASE + 32'h100; axi_awlen = 8'd3; axi_awsize = 3'd3;
        axi_awburst = 2'b01; axi_awvalid = 1'b1;
        check("abort_awready", 64'(axi_awready), 64'd1);
        @(negedge clock);
        axi_awvalid = 1'b0;
        for (int b = 0; b < 2; b++) begin
            axi_wdata = {$urandom, $urandom}; axi_wstrb = 8'hFF; axi_wlast = 1'b0; axi_wvalid = 1'b1;
            check("abort_wready", 64'(axi_wready), 64'd1);
            mm[midx(BASE + 32'h100 + 32'(8 * b))] = axi_wdata;
            @(negedge clock);
        end
        #2 reset = 1'b0;
        axi_wvalid = 1'b0;
        #1 chk_zero("midrst");
        @(negedge clock);
        reset = 1'b1;
        check("midrst_awready_release", 64'(axi_awready), 64'd0);
        @(negedge clock);
        check("midrst_awready_after", 64'(axi_awready), 64'd1);
        rd(4'd6, BASE + 32'h100, 8'd3, 3'd3, 2'b01, 0);

        rd(4'd4, 32'h7FFF_FFF8, 8'd0, 3'd3, 2'b01, 0);
        fill(2, 0);
        wr(4'd4, BASE + 32'(8 * MW) - 32'd8, 8'd1, 3'd3, 2'b01, -1, 1);
        rd(4'd4, BASE + 32'(8 * MW) - 32'd8, 8'd1, 3'd3, 2'b01, 0);
        rd(4'd4, BASE, 8'd1, 3'd3, 2'b01, 0);

        for (int unsigned it = 0; it < 40; it++) begin
            sz = $urandom_range(0, 4);
            st = 1 << ((sz > 3) ? 3 : sz);
            ln = $urandom_range(0, 15);
            ad = BASE + ($urandom_range(0, 8 * MW + 63) & ~(st - 1));
            if ($urandom_range(0, 1) == 1) begin
                fill(ln + 1, 1);
                wr(4'($urandom), ad, 8'(ln), 3'(sz), 2'($urandom_range(0, 3)),
                   ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, ln)) : -1,
                   $urandom_range(0, 3));
            end else begin
                rd(4'($urandom), ad, 8'(ln), 3'(sz), 2'($urandom_range(0, 3)), 2);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
